// File: rtl/seq_pattern_detector.sv
// Serial bit-pattern detector with KMP-style next-state tables that are built
// from PATTERN at elaboration. It offers Mealy or Moore match timing and a saturating match counter.
module seq_pattern_detector #(
  parameter int             LEN     = 3,
  parameter logic [LEN-1:0] PATTERN = 3'b100,
  parameter bit             OVERLAP = 1'b1,
  parameter bit             MOORE   = 1'b0,
  parameter int             CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic             count_sat
);

  localparam int SW = (LEN > 1) ? $clog2(LEN) : 1;

  typedef logic [SW-1:0] st_t;

  localparam st_t LAST = st_t'(LEN - 1);

  if (LEN < 2 || LEN > 16) begin : g_bad_len
    $error("seq_pattern_detector: LEN must be in 2..16");
  end
  if (CNT_W < 1) begin : g_bad_cnt
    $error("seq_pattern_detector: CNT_W must be at least 1");
  end

  // This function returns the length of the longest proper pattern prefix that is a suffix of
  // (prefix(st) followed by b). On a completing bit this is the border of the full pattern.
  function automatic int kmp_next(input int st, input logic b);
    int   best;
    int   kmax;
    int   j;
    logic c;
    logic ok;
    best = 0;
    kmax = (st + 1 < LEN) ? st + 1 : LEN - 1;
    for (int k = 1; k <= kmax; k++) begin
      ok = 1'b1;
      for (int i = 0; i < k; i++) begin
        j = st + 1 - k + i;
        c = (j == st) ? b : PATTERN[LEN-1-j];
        if (c != PATTERN[LEN-1-i]) ok = 1'b0;
      end
      if (ok) best = k;
    end
    return best;
  endfunction

  logic [LEN-1:0][SW-1:0] nxt0_tbl;
  logic [LEN-1:0][SW-1:0] nxt1_tbl;

  for (genvar s = 0; s < LEN; s++) begin : g_tbl
    assign nxt0_tbl[s] = st_t'(kmp_next(s, 1'b0));
    assign nxt1_tbl[s] = st_t'(kmp_next(s, 1'b1));
  end

  st_t              st_q, st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             completion;

  // NOTE: combinational blocks assign every output a default first, so no latch is inferred.
  always_comb begin
    st_d       = st_q;
    cnt_d      = cnt_q;
    completion = in_valid && (st_q == LAST) && (in_bit == PATTERN[0]);
    if (in_valid) begin
      st_d = in_bit ? nxt1_tbl[st_q] : nxt0_tbl[st_q];
    end
    if (completion && !OVERLAP) begin
      st_d = '0;
    end
    if (completion && !count_sat) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments, so all flops sample the same pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      st_q  <= '0;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
    end
  end

  if (MOORE) begin : g_moore
    logic match_q;
    always_ff @(posedge clk) begin
      if (reset || clear) match_q <= 1'b0;
      else                match_q <= completion;
    end
    assign match = match_q;
  end else begin : g_mealy
    assign match = completion && !reset && !clear;
  end

  assign match_count = cnt_q;
  assign count_sat   = &cnt_q;

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Scoreboard bench for seq_pattern_detector. Six differently parameterised instances share one
// input stream, and a bit-history reference model predicts match, count and saturation every cycle.
module tb_seq_pattern_detector;

  localparam int NI = 6;
  localparam int P_LEN   [NI] = '{3, 3, 4, 4, 5, 4};
  localparam int P_PAT   [NI] = '{4, 4, 10, 10, 27, 10};
  localparam bit P_OV    [NI] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  localparam bit P_MOORE [NI] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  localparam int P_CW    [NI] = '{2, 8, 8, 8, 3, 4};

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clear = 1'b0;
  logic in_valid = 1'b0;
  logic in_bit = 1'b0;

  logic [NI-1:0]       match_w;
  logic [NI-1:0]       sat_w;
  logic [NI-1:0][15:0] cnt_w;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic [P_CW[g]-1:0] cnt;
    seq_pattern_detector #(
      .LEN     (P_LEN[g]),
      .PATTERN (P_LEN[g]'(P_PAT[g])),
      .OVERLAP (P_OV[g]),
      .MOORE   (P_MOORE[g]),
      .CNT_W   (P_CW[g])
    ) u_dut (
      .clk         (clk),
      .reset       (reset),
      .clear       (clear),
      .in_valid    (in_valid),
      .in_bit      (in_bit),
      .match       (match_w[g]),
      .match_count (cnt),
      .count_sat   (sat_w[g])
    );
    assign cnt_w[g] = 16'(cnt);
  end

  typedef struct packed {
    logic [NI-1:0]       m;
    logic [NI-1:0]       s;
    logic [NI-1:0][15:0] c;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   stim_done = 1'b0;

  // This is the reference model state. It tracks the accepted bits since the search last restarted.
  int m_hist [NI];
  int m_len  [NI];
  int m_cnt  [NI];
  bit m_mq   [NI];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Each call applies one cycle of inputs. It queues what the DUTs must show during that cycle and then
  // advances the model across the following edge.
  task automatic cyc(input logic r, input logic c, input logic v, input logic b);
    exp_t e;
    bit   comp;
    int   mask;
    int   maxc;
    int   bb;
    @(negedge clk);
    reset    = r;
    clear    = c;
    in_valid = v;
    in_bit   = b;
    bb = (v && b === 1'b1) ? 1 : 0;
    for (int i = 0; i < NI; i++) begin
      mask = (1 << P_LEN[i]) - 1;
      maxc = (1 << P_CW[i]) - 1;
      comp = v && (m_len[i] + 1 >= P_LEN[i]) &&
             ((((m_hist[i] << 1) | bb) & mask) == P_PAT[i]);
      e.c[i] = 16'(m_cnt[i]);
      e.s[i] = (m_cnt[i] == maxc);
      e.m[i] = P_MOORE[i] ? m_mq[i] : (comp && !r && !c);
      if (r || c) begin
        m_hist[i] = 0;
        m_len[i]  = 0;
        m_cnt[i]  = 0;
        m_mq[i]   = 1'b0;
      end else begin
        m_mq[i] = comp;
        if (v) begin
          m_hist[i] = ((m_hist[i] << 1) | bb) & 16'hffff;
          if (m_len[i] < 32) m_len[i]++;
          if (comp) begin
            if (m_cnt[i] < maxc) m_cnt[i]++;
            if (!P_OV[i]) m_len[i] = 0;
          end
        end
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic bits(input logic [15:0] seq, input int n);
    logic [15:0] s;
    s = seq;
    for (int k = n - 1; k >= 0; k--) cyc(1'b0, 1'b0, 1'b1, s[k]);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_clear();
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  // The monitor samples once per cycle, mid low phase, after inputs settle and away from the rising edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        for (int i = 0; i < NI; i++) begin
          check($sformatf("match[%0d]", i), 16'(match_w[i]), 16'(e.m[i]));
          check($sformatf("count[%0d]", i), cnt_w[i], e.c[i]);
          check($sformatf("sat[%0d]", i), 16'(sat_w[i]), 16'(e.s[i]));
        end
      end
    end
  end

  initial begin : stimulus
    for (int i = 0; i < NI; i++) begin
      m_hist[i] = 0;
      m_len[i]  = 0;
      m_cnt[i]  = 0;
      m_mq[i]   = 1'b0;
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b1);

    // The stream 1,0,0,0 gives one match on the third bit (Mealy) or in the cycle after it (Moore).
    bits(16'b1000, 4);
    idle();
    #3;
    check("t1_mealy_count", cnt_w[0], 16'd1);
    check("t2_moore_count", cnt_w[1], 16'd1);
    do_clear();

    // The stream 1,0,1,0,1,0 against 1010 gives two matches when overlapping and one when not.
    bits(16'b101010, 6);
    idle();
    #3;
    check("t3_overlap_count", cnt_w[2], 16'd2);
    check("t3_nonoverlap_count", cnt_w[3], 16'd1);
    do_clear();

    // Bits are spaced by invalid cycles, and in_bit toggles or is X while in_valid is low.
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'bx);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'bx);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    idle();
    #3;
    check("t4_gapped_count", cnt_w[0], 16'd1);
    do_clear();

    // The 2-bit counter saturates at 3 from the third match, and a clear then zeroes it.
    for (int k = 0; k < 5; k++) bits(16'b100, 3);
    idle();
    #3;
    check("t5_sat_count", cnt_w[0], 16'd3);
    check("t5_sat_flag", 16'(sat_w[0]), 16'd1);
    do_clear();
    idle();
    #3;
    check("t5_cleared_count", cnt_w[0], 16'd0);
    check("t5_cleared_flag", 16'(sat_w[0]), 16'd0);

    // A reset mid-prefix discards the partial match.
    bits(16'b10, 2);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    bits(16'b0100, 4);
    idle();
    #3;
    check("t6_reset_count", cnt_w[0], 16'd1);
    do_clear();

    // A completing bit that arrives together with clear is dropped.
    bits(16'b10, 2);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    idle();
    #3;
    check("t6_clear_completion", cnt_w[0], 16'd0);

    // The randomized phase is biased toward valid bits, with occasional clear and reset.
    for (int k = 0; k < 3000; k++) begin
      cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 199) == 0),
          ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
    end
    idle();
    idle();
    stim_done = 1'b1;
  end

  initial begin : finisher
    int budget;
    budget = 0;
    wait (stim_done);
    while (exp_q.size() > 0 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    #5;
    check("scoreboard_drained", 16'(exp_q.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
